// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported data memory.
// Optional grant-hold (lock) support is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter (
  input  logic        clk,
  input  logic        areset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        req, we_in, lock_in;
  logic [1:0][31:0]  addr_in, wdata_in;
  logic              win_reg, last_reg, we_reg;
  logic [31:0]       addr_reg, wdata_reg;
  logic [1:0]        elig;
  logic              arb_go, pick, lock_hold, in_access;
  logic [1:0]        gnt, done;
  logic [1:0][31:0]  rdata_out;

  assign req      = {m1_req, m0_req};
  assign we_in    = {m1_we, m0_we};
  assign lock_in  = {m1_lock, m0_lock};
  assign addr_in  = {m1_addr, m0_addr};
  assign wdata_in = {m1_wdata, m0_wdata};

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [2:0] LOCK_MAX = 3'd4;
  logic [2:0] lock_cnt_reg;

  // The completing requester keeps the bus only while its locked-grant budget lasts.
  assign lock_hold = (state_reg == RESP) && req[win_reg] && lock_in[win_reg] &&
                     (lock_cnt_reg != LOCK_MAX);

  always_ff @(posedge clk) begin
    if (areset) begin
      lock_cnt_reg <= '0;
    end else if (arb_go) begin
      lock_cnt_reg <= lock_hold ? lock_cnt_reg + 3'd1 : 3'd0;
    end
  end
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = ^lock_in;
`endif

  always_comb begin
    elig       = '0;
    state_next = state_reg;
    // In RESP the finishing requester still holds req, so mask it out.
    if (state_reg == IDLE) begin
      elig = req;
    end else if (state_reg == RESP) begin
      elig = req;
      if (!lock_hold) begin
        elig[win_reg] = 1'b0;
      end
    end
    arb_go = |elig;
    if (lock_hold) begin
      pick = win_reg;
    end else if (&elig) begin
      pick = ~last_reg;
    end else begin
      pick = elig[1];
    end
    case (state_reg)
      IDLE:    state_next = arb_go ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = arb_go ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      win_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (arb_go) begin
        win_reg   <= pick;
        last_reg  <= pick;
        we_reg    <= we_in[pick];
        addr_reg  <= addr_in[pick];
        wdata_reg <= wdata_in[pick];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_port
      logic [31:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (areset) begin
          rdata_reg <= '0;
        end else if ((state_reg == ACCESS) && (win_reg == 1'(gi)) && !we_reg) begin
          rdata_reg <= mem_rd;
        end
      end

      assign gnt[gi]       = !areset && (state_reg == ACCESS) && (win_reg == 1'(gi));
      assign done[gi]      = !areset && (state_reg == RESP) && (win_reg == 1'(gi));
      assign rdata_out[gi] = areset ? '0 : rdata_reg;
    end
  endgenerate

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign m0_done  = done[0];
  assign m1_done  = done[1];
  assign m0_rdata = rdata_out[0];
  assign m1_rdata = rdata_out[1];

  // Reset masks the bus so an abandoned write never reaches memory.
  assign in_access = !areset && (state_reg == ACCESS);
  assign mem_we    = in_access && we_reg;
  assign mem_addr  = in_access ? addr_reg : '0;
  assign mem_wd    = in_access ? wdata_reg : '0;

endmodule
